// File: rtl/dstarb_link_pkg.sv
// dstarb_link_pkg: shared definitions for the DStarB serial frame link.
//   frame_state_t          frame receiver state, also visible on the debug state port
//   DSTARB_FRAME_BYTES     characters per frame
//   DSTARB_BITS_PER_CHAR   start + 8 data + stop
//   DSTARB_CLKS_PER_BIT    default clocks per bit period (1 Mbaud from 10 MHz)
//   DSTARB_GAP_LIMIT       default maximum idle bit periods between characters
package dstarb_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4
   } frame_state_t;

   localparam int DSTARB_FRAME_BYTES   = 8;
   localparam int DSTARB_BITS_PER_CHAR = 10;
   localparam int DSTARB_CLKS_PER_BIT  = 10;
   localparam int DSTARB_GAP_LIMIT     = 20;

endpackage

// File: rtl/dstarb_char_rx.sv
// dstarb_char_rx: character-level 8N1 deserializer for one DStarB line.
//   clk, rst   receive clock, asynchronous active-high reset
//   rxd        raw serial line (asynchronous, idles high)
//   rxd_s      synchronized line level
//   fall       synchronized falling edge (combinational from the edge register)
//   state      character state (ST_IDLE/ST_START/ST_DATA/ST_STOP)
//   byte_data  received byte, valid while byte_done is high
//   byte_done  stop bit sampled 1 this cycle
//   stop_err   stop bit sampled 0 this cycle
// The character FSM returns to ST_IDLE on a start-bit glitch without any
// indication; the frame level decides whether that means IDLE or GAP.
module dstarb_char_rx
   import dstarb_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = DSTARB_CLKS_PER_BIT
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       rxd_s,
   output logic       fall,
   output logic [2:0] state,
   output logic [7:0] byte_data,
   output logic       byte_done,
   output logic       stop_err
);

   localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0] DATA_LAST = 3'(DSTARB_BITS_PER_CHAR - 3);

   logic         sync1_q, sync2_q, prev_q;
   frame_state_t state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [2:0]   bit_q, bit_d;
   logic [7:0]   sh_q, sh_d;

   // Synchronizer and edge register reset to the idle (high) line level so
   // reset release never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rxd_s = sync2_q;
   assign fall  = prev_q & ~sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         bit_q   <= 3'd0;
         sh_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      byte_done = 1'b0;
      stop_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d = ST_START;
               cnt_d   = 8'd0;
            end
         end
         ST_START: begin
            // Half-bit check: a line that is high again was only a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = 8'd0;
               bit_d   = 3'd0;
               state_d = rxd_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = 8'd0;
               sh_d  = {rxd_s, sh_q[7:1]};
               if (bit_q == DATA_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = 8'd0;
               state_d   = ST_IDLE;
               byte_done = rxd_s;
               stop_err  = ~rxd_s;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign state     = state_q;
   assign byte_data = sh_q;

endmodule

// File: rtl/dstarb_frame_rx.sv
// dstarb_frame_rx: DStarB 64-bit frame receiver (8 characters, 8N1).
//   I_clk, I_rst   receive clock, asynchronous active-high reset
//   I_rxd          serial line from the IBUFDS, idles high
//   O_data         last complete frame, character 0 in [7:0]
//   O_data_valid   one-cycle pulse when O_data is updated
//   O_frame_err    one-cycle pulse when a partial frame is discarded
//   O_busy         high from start-bit detection until the frame ends
//   O_state        debug view of the frame FSM (frame_state_t encoding)
// Strobe semantics: O_data_valid and O_frame_err are single-cycle pulses with
// no ready/backpressure; the consumer must take O_data in the pulse cycle or
// later (O_data holds until the next good frame). They are never high together.
module dstarb_frame_rx
   import dstarb_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = DSTARB_CLKS_PER_BIT,
   parameter int GAP_LIMIT    = DSTARB_GAP_LIMIT
)
(
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_rxd,
   output logic [63:0] O_data,
   output logic        O_data_valid,
   output logic        O_frame_err,
   output logic        O_busy,
   output logic [2:0]  O_state
);

   localparam logic [15:0] GAP_LAST  = 16'(GAP_LIMIT * CLKS_PER_BIT - 1);
   localparam logic [2:0]  LAST_BYTE = 3'(DSTARB_FRAME_BYTES - 1);

   logic        rxd_s, fall, byte_done, stop_err, in_gap;
   logic [2:0]  char_state;
   logic [7:0]  byte_data;
   logic [2:0]  byte_cnt_q;
   logic [55:0] asm_q;
   logic [15:0] gap_cnt_q;
   logic [63:0] data_q;
   logic        valid_q, err_q;

   dstarb_char_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_char (
      .clk       (I_clk),
      .rst       (I_rst),
      .rxd       (I_rxd),
      .rxd_s     (rxd_s),
      .fall      (fall),
      .state     (char_state),
      .byte_data (byte_data),
      .byte_done (byte_done),
      .stop_err  (stop_err)
   );

   // GAP is the character receiver idling with a partial frame collected.
   assign in_gap = (char_state == ST_IDLE) && (byte_cnt_q != 3'd0);

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         byte_cnt_q <= 3'd0;
         asm_q      <= 56'd0;
         gap_cnt_q  <= 16'd0;
         data_q     <= 64'd0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (stop_err) begin
            err_q      <= 1'b1;
            byte_cnt_q <= 3'd0;
         end else if (byte_done) begin
            if (byte_cnt_q == LAST_BYTE) begin
               data_q     <= {byte_data, asm_q};
               valid_q    <= 1'b1;
               byte_cnt_q <= 3'd0;
            end else begin
               for (int i = 0; i < DSTARB_FRAME_BYTES - 1; i++) begin
                  if (byte_cnt_q == 3'(i)) asm_q[i*8 +: 8] <= byte_data;
               end
               byte_cnt_q <= byte_cnt_q + 3'd1;
            end
         end
         // A falling edge is tested before the timeout so it wins a tie.
         if (!in_gap || fall) begin
            gap_cnt_q <= 16'd0;
         end else if (rxd_s) begin
            if (gap_cnt_q == GAP_LAST) begin
               err_q      <= 1'b1;
               byte_cnt_q <= 3'd0;
               gap_cnt_q  <= 16'd0;
            end else begin
               gap_cnt_q <= gap_cnt_q + 16'd1;
            end
         end
      end
   end

   assign O_data       = data_q;
   assign O_data_valid = valid_q;
   assign O_frame_err  = err_q;
   assign O_busy       = (char_state != ST_IDLE) || (byte_cnt_q != 3'd0);
   assign O_state      = (char_state != ST_IDLE) ? char_state :
                         (in_gap ? ST_GAP : ST_IDLE);

endmodule

// File: tb/tb_dstarb_frame_rx.sv
// tb_dstarb_frame_rx: directed bench for dstarb_frame_rx (CLKS_PER_BIT=10,
// GAP_LIMIT=20). Stimulus pushes expected events {is_err, O_data} into
// exp_q; a negedge monitor pops and compares on every strobe.
module tb_dstarb_frame_rx;

   localparam int CPB = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxd;
   logic [63:0] O_data;
   logic        O_data_valid;
   logic        O_frame_err;
   logic        O_busy;
   logic [2:0]  O_state;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          last_char_start = 0;
   int          err_cyc = 0;
   int          valid_cyc[$];
   logic [64:0] exp_q[$];
   logic [64:0] mon_e;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dstarb_frame_rx #(
      .CLKS_PER_BIT (CPB),
      .GAP_LIMIT    (20)
   ) dut (
      .I_clk        (clk),
      .I_rst        (rst),
      .I_rxd        (rxd),
      .O_data       (O_data),
      .O_data_valid (O_data_valid),
      .O_frame_err  (O_frame_err),
      .O_busy       (O_busy),
      .O_state      (O_state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks (all called on a negedge) ----------------
   task automatic send_char(input logic [7:0] b, input bit stop_ok);
      last_char_start = cyc;
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_ok;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic glitch();
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic send_frame(input logic [63:0] d, input int n, input int bad_idx,
                             input int gap_idx, input int gap_len, input bit gap_glitch);
      for (int i = 0; i < n; i++) begin
         send_char(d[i*8 +: 8], i != bad_idx);
         if (i == gap_idx) begin
            idle(gap_len);
            if (gap_glitch) begin
               glitch();
               idle(gap_len);
            end
         end
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && (O_data_valid || O_frame_err)) begin
         check("valid_err_mutex", 64'(O_data_valid & O_frame_err), 64'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: valid=%b err=%b data=%h with nothing expected (cycle %0d)",
                     O_data_valid, O_frame_err, O_data, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_is_err", 64'(O_frame_err), 64'(mon_e[64]));
            check("event_data", O_data, mon_e[63:0]);
            check("busy_low_at_event", 64'(O_busy), 64'd0);
         end
         if (O_data_valid) valid_cyc.push_back(cyc);
         if (O_frame_err) err_cyc = cyc;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data", O_data, 64'd0);
      check("reset_valid", 64'(O_data_valid), 64'd0);
      check("reset_err", 64'(O_frame_err), 64'd0);
      check("reset_busy", 64'(O_busy), 64'd0);
      check("reset_state", 64'(O_state), 64'd0);
      rst = 1'b0;
      idle(10);

      // 1: single clean frame; after char 0 the FSM is in GAP and busy
      exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
      send_char(8'hEF, 1'b1);
      check("t1_busy_in_gap", 64'(O_busy), 64'd1);
      check("t1_state_gap", 64'(O_state), 64'd4);
      send_frame(64'h0123_4567_89AB_CD00 >> 8, 7, -1, -1, 0, 1'b0);
      idle(20);
      check("t1_busy_after", 64'(O_busy), 64'd0);

      // 2: bad stop bit on char 3, O_data must hold the previous frame
      exp_q.push_back({1'b1, 64'h0123_4567_89AB_CDEF});
      send_frame(64'h1111_2222_3333_4444, 4, 3, -1, 0, 1'b0);
      idle(30);
      exp_q.push_back({1'b0, 64'hA5A5_5A5A_0000_FFFF});
      send_frame(64'hA5A5_5A5A_0000_FFFF, 8, -1, -1, 0, 1'b0);
      idle(30);

      // 3: glitch on idle line, then glitch inside the gap after char 2
      glitch();
      idle(30);
      check("t3_idle_glitch_busy", 64'(O_busy), 64'd0);
      exp_q.push_back({1'b0, 64'h1122_3344_5566_7788});
      send_frame(64'h1122_3344_5566_7788, 8, -1, 2, 20, 1'b1);
      idle(30);

      // 4: 250-cycle gap after char 5 times out 200 cycles into GAP:
      // START +3, stop sample +3+5+90 = +98, timeout +98+200 = +298
      exp_q.push_back({1'b1, 64'h1122_3344_5566_7788});
      send_frame(64'h9999_8888_7777_6666, 6, -1, 5, 250, 1'b0);
      check("t4_timeout_cycle", 64'(err_cyc - last_char_start), 64'd298);
      idle(20);
      exp_q.push_back({1'b0, 64'h0F1E_2D3C_4B5A_6978});
      send_frame(64'h0F1E_2D3C_4B5A_6978, 8, -1, 5, 150, 1'b0);
      idle(30);

      // 5: two frames back-to-back, valids 800 cycles apart
      valid_cyc.delete();
      exp_q.push_back({1'b0, 64'h8899_AABB_CCDD_EEFF});
      exp_q.push_back({1'b0, 64'h0011_2233_4455_6677});
      send_frame(64'h8899_AABB_CCDD_EEFF, 8, -1, -1, 0, 1'b0);
      send_frame(64'h0011_2233_4455_6677, 8, -1, -1, 0, 1'b0);
      idle(30);
      check("t5_valid_count", 64'(valid_cyc.size()), 64'd2);
      if (valid_cyc.size() == 2)
         check("t5_valid_spacing", 64'(valid_cyc[1] - valid_cyc[0]), 64'd800);

      // 6: reset in the middle of char 4 clears everything at once
      send_frame(64'h5555_6666_7777_8888, 4, -1, -1, 0, 1'b0);
      rxd = 1'b0;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      rxd = 1'b1;
      #1;
      check("t6_rst_data", O_data, 64'd0);
      check("t6_rst_valid", 64'(O_data_valid), 64'd0);
      check("t6_rst_err", 64'(O_frame_err), 64'd0);
      check("t6_rst_busy", 64'(O_busy), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(20);
      exp_q.push_back({1'b0, 64'hDEAD_BEEF_CAFE_F00D});
      send_frame(64'hDEAD_BEEF_CAFE_F00D, 8, -1, -1, 0, 1'b0);
      idle(30);

      // ---------------- final report ----------------
      check("leftover_expected", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
